// File: rtl/fft_bitrev_reorder_pkg.sv
// rtl/fft_bitrev_reorder_pkg.sv - shared FFT types, defaults and bit-reverse helper
package fft_bitrev_reorder_pkg;

    localparam int FFT_N_POINTS_DEFAULT = 64;
    localparam int FFT_LOG2N_DEFAULT    = $clog2(FFT_N_POINTS_DEFAULT);
    localparam int FFT_IDX_MAX          = 16;

    typedef struct packed {
        logic [15:0] data_r;
        logic [15:0] data_i;
    } fft_sample_t;

    typedef struct packed {
        logic        valid;
        fft_sample_t data;
    } DATA_BUS;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_t;

    // Reverse the low `width` bits of v; bits at and above `width` come back as zero.
    function automatic logic [FFT_IDX_MAX-1:0] bitrev(input logic [FFT_IDX_MAX-1:0] v,
                                                       input int width);
        logic [FFT_IDX_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < FFT_IDX_MAX; i++) begin
            if (i < width) begin
                r[i] = v[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// rtl/fft_reorder_bank.sv - simple dual-port RAM, one write port, one synchronous read port
module fft_reorder_bank #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are never cleared; a location is always written before the reader visits it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong bit-reversed to natural order reorder buffer (option: FFT_REORDER_FRAME_TAG_EN)
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int N_POINTS = FFT_N_POINTS_DEFAULT
) (
    input  logic    clk,
    input  logic    rst,
    input  DATA_BUS in,
    output DATA_BUS out,
    output logic    frame_done
`ifdef FFT_REORDER_FRAME_TAG_EN
    ,
    output logic                        out_sop,
    output logic [$clog2(N_POINTS)-1:0] out_index
`endif
);

    localparam int LOG2N = $clog2(N_POINTS);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);
    localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

    // Write side
    logic [LOG2N-1:0] wr_cnt;
    logic             wr_bank;
    logic             start_rd;
    logic [LOG2N-1:0] wr_rev;

    // Read side
    rd_state_t        state, state_nxt;
    logic [LOG2N-1:0] rd_cnt, rd_cnt_nxt;
    logic             rd_bank, rd_bank_nxt;
    logic             rd_en;
    logic             rd_last;
    logic [31:0]      rd_data;

    // Output pipeline, stage aligned with RAM read data
    logic             rd_vld_q;
    logic             rd_last_q;

    assign wr_rev = LOG2N'(bitrev(FFT_IDX_MAX'(wr_cnt), LOG2N));

    // Count accepted samples; on the last bin of a frame swap banks and kick the reader.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt   <= '0;
            wr_bank  <= 1'b0;
            start_rd <= 1'b0;
        end else begin
            start_rd <= 1'b0;
            if (in.valid) begin
                wr_cnt <= wr_cnt + ONE;
                if (wr_cnt == LAST_IDX) begin
                    wr_bank  <= ~wr_bank;
                    start_rd <= 1'b1;
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RD_IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_cnt  <= rd_cnt_nxt;
            rd_bank <= rd_bank_nxt;
        end
    end

    // Read FSM next state; the bank just filled is the one wr_bank has already left.
    always_comb begin
        state_nxt   = state;
        rd_cnt_nxt  = rd_cnt;
        rd_bank_nxt = rd_bank;
        rd_en       = 1'b0;
        rd_last     = 1'b0;
        case (state)
            RD_IDLE: begin
                if (start_rd) begin
                    state_nxt   = RD_DRAIN;
                    rd_cnt_nxt  = '0;
                    rd_bank_nxt = ~wr_bank;
                end
            end
            RD_DRAIN: begin
                rd_en      = 1'b1;
                rd_last    = (rd_cnt == LAST_IDX);
                rd_cnt_nxt = rd_cnt + ONE;
                if (rd_last) begin
                    if (start_rd) begin
                        rd_cnt_nxt  = '0;
                        rd_bank_nxt = ~wr_bank;
                    end else begin
                        state_nxt = RD_IDLE;
                    end
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    fft_reorder_bank #(
        .DEPTH (2 * N_POINTS),
        .AW    (LOG2N + 1),
        .DW    (32)
    ) u_bank (
        .clk     (clk),
        .wr_en   (in.valid),
        .wr_addr ({wr_bank, wr_rev}),
        .wr_data (in.data),
        .rd_en   (rd_en),
        .rd_addr ({rd_bank, rd_cnt}),
        .rd_data (rd_data)
    );

    // Two-stage output: flags track the RAM latency, then everything is registered onto out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            out        <= '0;
            frame_done <= 1'b0;
        end else begin
            rd_vld_q   <= rd_en;
            rd_last_q  <= rd_last;
            out.valid  <= rd_vld_q;
            out.data   <= rd_vld_q ? rd_data : '0;
            frame_done <= rd_vld_q & rd_last_q;
        end
    end

`ifdef FFT_REORDER_FRAME_TAG_EN
    logic [LOG2N-1:0] rd_idx_q;

    // Bin number follows the same two-stage path as the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_q  <= '0;
            out_sop   <= 1'b0;
            out_index <= '0;
        end else begin
            rd_idx_q  <= rd_en ? rd_cnt : '0;
            out_sop   <= rd_vld_q && (rd_idx_q == '0);
            out_index <= rd_vld_q ? rd_idx_q : '0;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - self-checking bench for fft_bitrev_reorder (N_POINTS=8)
module tb_fft_bitrev_reorder;
    import fft_bitrev_reorder_pkg::*;

    localparam int N = 8;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] data;
        logic        done;
        logic        sop;
        logic [2:0]  idx;
    } ent_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    DATA_BUS in;
    DATA_BUS out;
    logic    frame_done;
`ifdef FFT_REORDER_FRAME_TAG_EN
    logic       out_sop;
    logic [2:0] out_index;
`endif

    int          n_cmp = 0;
    int          n_fail = 0;
    int          idle_bad = 0;
    logic [31:0] cyc = '0;
    ent_t        in_log[$];
    ent_t        out_log[$];
    ent_t        exp_q[$];

    fft_bitrev_reorder #(.N_POINTS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .out        (out),
        .frame_done (frame_done)
`ifdef FFT_REORDER_FRAME_TAG_EN
        ,
        .out_sop    (out_sop),
        .out_index  (out_index)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepted inputs and produced outputs, timestamped by cycle.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            in_log.delete();
        end else if (in.valid) begin
            e = '0;
            e.cyc = cyc;
            e.data = in.data;
            in_log.push_back(e);
        end
        if (out.valid) begin
            e = '0;
            e.cyc = cyc;
            e.data = out.data;
            e.done = frame_done;
`ifdef FFT_REORDER_FRAME_TAG_EN
            e.sop = out_sop;
            e.idx = out_index;
`endif
            out_log.push_back(e);
        end else begin
            if (out.data !== '0 || frame_done !== 1'b0) idle_bad++;
`ifdef FFT_REORDER_FRAME_TAG_EN
            if (out_sop !== 1'b0 || out_index !== 3'd0) idle_bad++;
`endif
        end
    end

    // A frame completion must never land in the middle of a drain.
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (dut.start_rd === 1'b1 && dut.state == RD_DRAIN && dut.rd_cnt !== 3'd7) begin
                n_fail++;
                $display("FAIL start_rd_overlap: rd_cnt=%0d required 7 at cycle %0d", dut.rd_cnt, cyc);
            end
        end
    end

    // Reference: every N accepted samples form a frame; natural bin k is the
    // sample that arrived in position bitrev(k), output at last-arrival + 4 + k.
    task automatic build_expected();
        ent_t e;
        exp_q.delete();
        for (int f = 0; (f + 1) * N <= in_log.size(); f++) begin
            int t_last;
            t_last = int'(in_log[f*N + N - 1].cyc);
            for (int k = 0; k < N; k++) begin
                int src;
                src = 0;
                for (int b = 0; b < 3; b++) begin
                    if (((k >> b) & 1) == 1) src = src + (1 << (2 - b));
                end
                e = '0;
                e.cyc = 32'(t_last + 4 + k);
                e.data = in_log[f*N + src].data;
                e.done = (k == N - 1);
`ifdef FFT_REORDER_FRAME_TAG_EN
                e.sop = (k == 0);
                e.idx = 3'(k);
`endif
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] dr, input logic [15:0] di);
        @(posedge clk);
        #1;
        in.valid = v;
        in.data.data_r = dr;
        in.data.data_i = di;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0);
    endtask

    task automatic clear_logs();
        in_log.delete();
        out_log.delete();
    endtask

    task automatic test_reset();
        in = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out !== '0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: out=%h done=%b required 0 0", out, frame_done);
        end
        n_cmp++;
        if (dut.wr_cnt !== 3'd0 || dut.wr_bank !== 1'b0 || dut.state != RD_IDLE || dut.start_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: wr_cnt=%0d wr_bank=%b state=%0d start_rd=%b required 0 0 0 0",
                     dut.wr_cnt, dut.wr_bank, dut.state, dut.start_rd);
        end
`ifdef FFT_REORDER_FRAME_TAG_EN
        n_cmp++;
        if (out_sop !== 1'b0 || out_index !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_tag: sop=%b idx=%0d required 0 0", out_sop, out_index);
        end
`endif
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single();
        int tbl[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        clear_logs();
        for (int k = 0; k < N; k++) drive(1'b1, 16'(k), 16'(-k));
        idle(20);
        build_expected();
        n_cmp++;
        if (out_log.size() != N) begin
            n_fail++;
            $display("FAIL single_count: got %0d required %0d", out_log.size(), N);
        end
        for (int i = 0; i < N && i < out_log.size(); i++) begin
            n_cmp++;
            if (out_log[i].data[31:16] !== 16'(tbl[i]) || out_log[i].data[15:0] !== 16'(-tbl[i])) begin
                n_fail++;
                $display("FAIL single_order%0d: got %h required r=%0d i=-%0d", i, out_log[i].data, tbl[i], tbl[i]);
            end
            n_cmp++;
            if (out_log[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single_bin%0d: got cyc=%0d data=%h done=%b sop=%b idx=%0d required cyc=%0d data=%h done=%b sop=%b idx=%0d",
                         i, out_log[i].cyc, out_log[i].data, out_log[i].done, out_log[i].sop, out_log[i].idx,
                         exp_q[i].cyc, exp_q[i].data, exp_q[i].done, exp_q[i].sop, exp_q[i].idx);
            end
        end
    endtask

    task automatic test_bursty();
        clear_logs();
        for (int k = 0; k < N; k++) begin
            drive(1'b1, 16'(k), 16'(-k));
            drive(1'b0, 16'h0, 16'h0);
        end
        idle(20);
        build_expected();
        n_cmp++;
        if (out_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bursty_count: got %0d required %0d", out_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
            n_cmp++;
            if (out_log[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bursty_bin%0d: got cyc=%0d data=%h done=%b required cyc=%0d data=%h done=%b",
                         i, out_log[i].cyc, out_log[i].data, out_log[i].done,
                         exp_q[i].cyc, exp_q[i].data, exp_q[i].done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        clear_logs();
        for (int k = 0; k < 2 * N; k++) drive(1'b1, 16'(k), 16'($urandom));
        idle(24);
        build_expected();
        n_cmp++;
        if (out_log.size() != 2 * N) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d required %0d", out_log.size(), 2 * N);
        end
        dones = 0;
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
            if (out_log[i].done) dones++;
            n_cmp++;
            if (out_log[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_bin%0d: got cyc=%0d data=%h done=%b required cyc=%0d data=%h done=%b",
                         i, out_log[i].cyc, out_log[i].data, out_log[i].done,
                         exp_q[i].cyc, exp_q[i].data, exp_q[i].done);
            end
        end
        n_cmp++;
        if (dones != 2) begin
            n_fail++;
            $display("FAIL b2b_frame_done: got %0d pulses required 2", dones);
        end
    endtask

    task automatic test_random_gaps();
        clear_logs();
        for (int s = 0; s < 3 * N; s++) begin
            idle(int'($urandom_range(0, 2)));
            drive(1'b1, 16'($urandom), 16'($urandom));
        end
        idle(24);
        build_expected();
        n_cmp++;
        if (out_log.size() != 3 * N) begin
            n_fail++;
            $display("FAIL rand_count: got %0d required %0d", out_log.size(), 3 * N);
        end
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
            n_cmp++;
            if (out_log[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_bin%0d: got cyc=%0d data=%h done=%b required cyc=%0d data=%h done=%b",
                         i, out_log[i].cyc, out_log[i].data, out_log[i].done,
                         exp_q[i].cyc, exp_q[i].data, exp_q[i].done);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        for (int k = 0; k < 5; k++) drive(1'b1, 16'(100 + k), 16'($urandom));
        @(posedge clk);
        #1;
        in = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < N; k++) drive(1'b1, 16'(20 + k), 16'($urandom));
        idle(20);
        build_expected();
        n_cmp++;
        if (out_log.size() != N || exp_q.size() != N) begin
            n_fail++;
            $display("FAIL midframe_count: got %0d required %0d", out_log.size(), N);
        end
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
            n_cmp++;
            if (out_log[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midframe_bin%0d: got cyc=%0d data=%h required cyc=%0d data=%h",
                         i, out_log[i].cyc, out_log[i].data, exp_q[i].cyc, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        ent_t pre[$];
        logic found;
        clear_logs();
        for (int k = 0; k < N; k++) drive(1'b1, 16'($urandom), 16'($urandom));
        idle(1);
        build_expected();
        pre = exp_q;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (pre.size() == N && cyc == pre[3].cyc) found = 1'b1;
        end
        n_cmp++;
        if (!found || out.valid !== 1'b1 || out.data !== pre[3].data) begin
            n_fail++;
            $display("FAIL drain_bin3: found=%b valid=%b data=%h required 1 1 %h",
                     found, out.valid, out.data, (pre.size() == N) ? pre[3].data : 32'h0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (out.valid !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_reset_out: valid=%b done=%b required 0 0", out.valid, frame_done);
        end
        idle(20);
        n_cmp++;
        if (out_log.size() != 4) begin
            n_fail++;
            $display("FAIL drain_truncated: got %0d outputs required 4", out_log.size());
        end
        for (int i = 0; i < 4 && i < out_log.size() && i < pre.size(); i++) begin
            n_cmp++;
            if (out_log[i] !== pre[i]) begin
                n_fail++;
                $display("FAIL drain_bin%0d: got cyc=%0d data=%h required cyc=%0d data=%h",
                         i, out_log[i].cyc, out_log[i].data, pre[i].cyc, pre[i].data);
            end
        end
        clear_logs();
        for (int k = 0; k < N; k++) drive(1'b1, 16'($urandom), 16'($urandom));
        idle(20);
        build_expected();
        n_cmp++;
        if (out_log.size() != N) begin
            n_fail++;
            $display("FAIL drain_recover_count: got %0d required %0d", out_log.size(), N);
        end
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
            n_cmp++;
            if (out_log[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL drain_recover_bin%0d: got cyc=%0d data=%h required cyc=%0d data=%h",
                         i, out_log[i].cyc, out_log[i].data, exp_q[i].cyc, exp_q[i].data);
            end
        end
    endtask

    task automatic test_idle_zero();
        n_cmp++;
        if (idle_bad != 0) begin
            n_fail++;
            $display("FAIL idle_zero: got %0d non-zero idle cycles required 0", idle_bad);
        end
    endtask

    initial begin
        in = '0;
        test_reset();
        test_single();
        test_bursty();
        test_back_to_back();
        test_random_gaps();
        test_reset_mid_frame();
        test_reset_mid_drain();
        test_idle_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
